// File: rtl/cmos_cfg_pkg.sv
// cmos_cfg_pkg: shared definitions for the CMOS sensor configuration sequencer.
// Holds the FSM state encoding, the table entry layout, the two reserved
// register addresses (end-of-table and delay marker) and the ms-to-ticks helper.
package cmos_cfg_pkg;

    localparam int REG_ADDR_W = 16;
    localparam int REG_VAL_W  = 8;
    localparam int ENTRY_W    = REG_ADDR_W + REG_VAL_W;
    localparam int IDX_W      = 8;
    localparam int ROM_DEPTH  = 256;
    localparam int MAX_RETRY  = 3;

    localparam logic [REG_ADDR_W-1:0] CFG_END = 16'hFFFF;
    localparam logic [REG_ADDR_W-1:0] CFG_DLY = 16'hFFFE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DELAY,
        S_FINISH,
        S_ERROR
    } state_t;

    // Counter load value for an ms-denominated wait; the counter runs down to
    // zero inclusive, hence the -1. Product is deliberately truncated to 32 bits.
    function automatic logic [31:0] ms_to_ticks(input logic [31:0] ms,
                                                input logic [31:0] tpm);
        return (ms * tpm) - 32'd1;
    endfunction

endpackage

// File: rtl/cmos_cfg_rom.sv
// cmos_cfg_rom: synchronous 256x24 register-table ROM, one cycle read latency.
// Contents come in through the INIT parameter, which the integration flow fills
// from the sensor's init file (entry i occupies bits [i*24 +: 24], each entry
// laid out as {reg_addr[15:0], value[7:0]}).
// Ports:
//   clk_i   in   1   clock
//   addr_i  in   8   table index
//   data_o  out  24  entry at addr_i, valid the cycle after addr_i
module cmos_cfg_rom
    import cmos_cfg_pkg::*;
#(
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] INIT = '0
) (
    input  logic               clk_i,
    input  logic [IDX_W-1:0]   addr_i,
    output logic [ENTRY_W-1:0] data_o
);

    logic [ENTRY_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        data_q <= INIT[32'(addr_i) * ENTRY_W +: ENTRY_W];
    end

    assign data_o = data_q;

endmodule

// File: rtl/cmos_cfg_seq.sv
// cmos_cfg_seq: walks a register table after power-up and issues each entry as
// an SCCB write. Entries with reg_addr FFFF end the pass, FFFE inserts a delay
// of <value> ms. Reaching the last table slot ends the pass without wrapping.
// Optional feature (macro CMOS_CFG_RETRY_EN): a NACKed write is reissued up to
// three times before the pass aborts; without it the first NACK aborts.
// Ports:
//   iCLK/iRST              clock, synchronous active-high reset
//   iSTART                 one-cycle start pulse, only honoured when idle
//   oROM_ADDR/iROM_DATA    table ROM interface (1-cycle latency)
//   oSCCB_REQ/ADDR/DATA    write request held until iSCCB_DONE
//   iSCCB_DONE/iSCCB_NACK  transfer completion and NACK qualifier
//   oBUSY/oDONE/oERR/oIDX  pass status and current/failing entry index
module cmos_cfg_seq
    import cmos_cfg_pkg::*;
#(
    parameter int TABLE_LEN    = 256,
    parameter int TICKS_PER_MS = 50000,
    parameter int PWRUP_MS     = 20
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    output logic [7:0]  oROM_ADDR,
    input  logic [23:0] iROM_DATA,
    output logic        oSCCB_REQ,
    output logic [15:0] oSCCB_ADDR,
    output logic [7:0]  oSCCB_DATA,
    input  logic        iSCCB_DONE,
    input  logic        iSCCB_NACK,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR,
    output logic [7:0]  oIDX
);

    localparam logic [IDX_W-1:0] LAST_IDX = 8'(TABLE_LEN - 1);

    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [31:0]           cnt_q;
    logic                  req_q;
    logic [REG_ADDR_W-1:0] sccb_addr_q;
    logic [REG_VAL_W-1:0]  sccb_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
`ifdef CMOS_CFG_RETRY_EN
    logic [1:0]            retry_q;
`endif

    logic [REG_ADDR_W-1:0] ent_addr;
    logic [REG_VAL_W-1:0]  ent_val;
    state_t                adv_state_d;
    logic [IDX_W-1:0]      adv_idx_d;
    logic [31:0]           dly_ticks_d;
    logic [31:0]           pwrup_ticks;

    assign ent_addr = iROM_DATA[ENTRY_W-1:REG_VAL_W];
    assign ent_val  = iROM_DATA[REG_VAL_W-1:0];

    // Moving past an entry: the last table slot ends the pass instead of wrapping.
    assign adv_state_d = (idx_q == LAST_IDX) ? S_FINISH : S_FETCH;
    assign adv_idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 8'd1;

    assign dly_ticks_d = ms_to_ticks(32'(ent_val), 32'(TICKS_PER_MS));
    assign pwrup_ticks = ms_to_ticks(32'(PWRUP_MS), 32'(TICKS_PER_MS));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            sccb_addr_q <= '0;
            sccb_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CMOS_CFG_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iSTART) begin
                        state_q <= S_PWRUP;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        cnt_q   <= pwrup_ticks;
                    end
                end
                S_PWRUP: begin
                    if (cnt_q == 32'd0) state_q <= S_FETCH;
                    else                cnt_q   <= cnt_q - 32'd1;
                end
                S_DELAY: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= adv_state_d;
                        idx_q   <= adv_idx_d;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                // oROM_ADDR mirrors idx_q, so the ROM samples it at the end of
                // this cycle and the entry is on iROM_DATA during DECODE.
                S_FETCH: begin
                    state_q <= S_DECODE;
`ifdef CMOS_CFG_RETRY_EN
                    // FETCH is only reached on a new entry, never on a retry.
                    retry_q <= '0;
`endif
                end
                S_DECODE: begin
                    if (ent_addr == CFG_END) begin
                        state_q <= S_FINISH;
                    end else if (ent_addr == CFG_DLY) begin
                        if (ent_val == '0) begin
                            state_q <= adv_state_d;
                            idx_q   <= adv_idx_d;
                        end else begin
                            cnt_q   <= dly_ticks_d;
                            state_q <= S_DELAY;
                        end
                    end else begin
                        sccb_addr_q <= ent_addr;
                        sccb_data_q <= ent_val;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    req_q   <= 1'b1;
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (iSCCB_DONE) begin
                        req_q <= 1'b0;
                        if (!iSCCB_NACK) begin
                            state_q <= adv_state_d;
                            idx_q   <= adv_idx_d;
                        end else begin
`ifdef CMOS_CFG_RETRY_EN
                            if (retry_q == 2'(MAX_RETRY)) begin
                                state_q <= S_ERROR;
                            end else begin
                                retry_q <= retry_q + 2'd1;
                                state_q <= S_ISSUE;
                            end
`else
                            state_q <= S_ERROR;
`endif
                        end
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_ERROR: begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oROM_ADDR  = idx_q;
    assign oIDX       = idx_q;
    assign oSCCB_REQ  = req_q;
    assign oSCCB_ADDR = sccb_addr_q;
    assign oSCCB_DATA = sccb_data_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oERR       = err_q;

endmodule

// File: tb/tb_cmos_cfg_seq.sv
// Bench for cmos_cfg_seq: behavioural table ROM, an SCCB slave model that
// compares every write against a scoreboard queue, and one task per scenario.
module tb_cmos_cfg_seq;

    localparam int TL  = 4;
    localparam int TPM = 10;
    localparam int PMS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic        oreq;
    logic [15:0] oaddr;
    logic [7:0]  odata;
    logic        sdone = 1'b0;
    logic        snack = 1'b0;
    logic        obusy, odone, oerr;
    logic [7:0]  oidx;

    cmos_cfg_seq #(.TABLE_LEN(TL), .TICKS_PER_MS(TPM), .PWRUP_MS(PMS)) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start),
        .oROM_ADDR(rom_addr), .iROM_DATA(rom_data),
        .oSCCB_REQ(oreq), .oSCCB_ADDR(oaddr), .oSCCB_DATA(odata),
        .iSCCB_DONE(sdone), .iSCCB_NACK(snack),
        .oBUSY(obusy), .oDONE(odone), .oERR(oerr), .oIDX(oidx)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [0:TL-1];
    always @(posedge clk) rom_data <= rom[rom_addr[1:0]];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nreq = 0;
    int st_cyc = 0;
    bit resp_en = 1'b0;
    logic [23:0] exp_q[$];
    bit          nack_q[$];
    int          req_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // SCCB slave model: every request is scored against exp_q, held for three
    // cycles with a stability check, then completed with the next NACK flag.
    initial begin
        logic [23:0] got, e;
        forever begin
            @(negedge clk);
            if (resp_en && oreq) begin
                got = {oaddr, odata};
                nreq++;
                req_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sccb_unexpected: got %h, required no request", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL sccb_write: got %h, required %h", got, e);
                    end
                end
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if ({oreq, oaddr, odata} !== {1'b1, got}) begin
                        errors++;
                        $display("FAIL sccb_hold: got %b/%h, required 1/%h", oreq, {oaddr, odata}, got);
                    end
                end
                snack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                sdone = 1'b1;
                @(negedge clk);
                sdone = 1'b0;
                snack = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!obusy) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic new_pass();
        exp_q.delete();
        nack_q.delete();
        req_cyc.delete();
        nreq = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (oreq !== 1'b0)   begin errors++; $display("FAIL rst_req: got %b, required 0", oreq); end
        checks++; if (obusy !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b, required 0", obusy); end
        checks++; if (odone !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b, required 0", odone); end
        checks++; if (oerr !== 1'b0)   begin errors++; $display("FAIL rst_err: got %b, required 0", oerr); end
        checks++; if (oidx !== 8'd0)   begin errors++; $display("FAIL rst_idx: got %h, required 00", oidx); end
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL rst_rom_addr: got %h, required 00", rom_addr); end
        checks++; if ({oaddr, odata} !== 24'd0) begin errors++; $display("FAIL rst_sccb: got %h, required 000000", {oaddr, odata}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        rom = '{24'h300882, 24'hFFFE05, 24'h310303, 24'hFFFF00};
        new_pass();
        exp_q.push_back(24'h300882);
        exp_q.push_back(24'h310303);
        resp_en = 1'b1;
        pulse_start();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: busy stuck, required idle"); end
        checks++; if (nreq != 2) begin errors++; $display("FAIL basic_nreq: got %0d, required 2", nreq); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: got %0d left, required 0", exp_q.size()); end
        if (req_cyc.size() >= 2) begin
            checks++;
            if (req_cyc[1] - req_cyc[0] < 50) begin errors++; $display("FAIL basic_gap: got %0d, required >=50", req_cyc[1] - req_cyc[0]); end
            checks++;
            if (req_cyc[0] - st_cyc < 10 || req_cyc[0] - st_cyc > 20) begin
                errors++; $display("FAIL basic_pwrup: got %0d, required 10..20", req_cyc[0] - st_cyc);
            end
        end
        checks++; if (odone !== 1'b1) begin errors++; $display("FAIL basic_done: got %b, required 1", odone); end
        checks++; if (oerr !== 1'b0)  begin errors++; $display("FAIL basic_err: got %b, required 0", oerr); end
        checks++; if (oidx !== 8'd3)  begin errors++; $display("FAIL basic_idx: got %0d, required 3", oidx); end
    endtask

    task automatic test_nack();
        bit to;
        rom = '{24'h300882, 24'h310303, 24'h310404, 24'hFFFF00};
        new_pass();
`ifdef CMOS_CFG_RETRY_EN
        exp_q = '{24'h300882, 24'h310303, 24'h310303, 24'h310303, 24'h310303, 24'h310404};
        nack_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        pulse_start();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL retry_timeout: busy stuck, required idle"); end
        checks++; if (nreq != 6) begin errors++; $display("FAIL retry_nreq: got %0d, required 6", nreq); end
        checks++; if (odone !== 1'b1) begin errors++; $display("FAIL retry_done: got %b, required 1", odone); end
        checks++; if (oerr !== 1'b0)  begin errors++; $display("FAIL retry_err: got %b, required 0", oerr); end
        checks++; if (oidx !== 8'd3)  begin errors++; $display("FAIL retry_idx: got %0d, required 3", oidx); end
`else
        exp_q = '{24'h300882, 24'h310303};
        nack_q = '{1'b0, 1'b1};
        pulse_start();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL nack_timeout: busy stuck, required idle"); end
        checks++; if (oerr !== 1'b1)  begin errors++; $display("FAIL nack_err: got %b, required 1", oerr); end
        checks++; if (odone !== 1'b0) begin errors++; $display("FAIL nack_done: got %b, required 0", odone); end
        checks++; if (oidx !== 8'd1)  begin errors++; $display("FAIL nack_idx: got %0d, required 1", oidx); end
        repeat (30) @(negedge clk);
        checks++; if (nreq != 2) begin errors++; $display("FAIL nack_nreq: got %0d, required 2", nreq); end
`endif
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL nack_missing: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_in_wait_ack();
        bit to, seen, bad;
        rom = '{24'h300882, 24'hFFFE05, 24'h310303, 24'hFFFF00};
        new_pass();
        resp_en = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (oreq) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rwa_req_seen: got none, required request"); end
        checks++; if (oaddr !== 16'h3008) begin errors++; $display("FAIL rwa_addr: got %h, required 3008", oaddr); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (oreq !== 1'b0)  begin errors++; $display("FAIL rwa_req_drop: got %b, required 0", oreq); end
        checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL rwa_busy: got %b, required 0", obusy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sdone = 1'b1;
        @(negedge clk);
        sdone = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (obusy || oreq || odone || oerr) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rwa_stray_done: got activity, required idle"); end
        exp_q = '{24'h300882, 24'h310303};
        resp_en = 1'b1;
        pulse_start();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL rwa_timeout: busy stuck, required idle"); end
        checks++; if (nreq != 2) begin errors++; $display("FAIL rwa_nreq: got %0d, required 2", nreq); end
        checks++; if (odone !== 1'b1) begin errors++; $display("FAIL rwa_done: got %b, required 1", odone); end
        checks++; if (oidx !== 8'd3)  begin errors++; $display("FAIL rwa_idx: got %0d, required 3", oidx); end
    endtask

    task automatic test_start_in_delay();
        bit to, ok;
        rom = '{24'h300882, 24'hFFFE02, 24'h310303, 24'h310404};
        new_pass();
        exp_q = '{24'h300882, 24'h310303, 24'h310404};
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (nreq == 1 && !oreq) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL sid_first_write: got %0d writes, required 1", nreq); end
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL sid_timeout: busy stuck, required idle"); end
        checks++; if (nreq != 3) begin errors++; $display("FAIL sid_nreq: got %0d, required 3", nreq); end
        checks++; if (odone !== 1'b1) begin errors++; $display("FAIL sid_done: got %b, required 1", odone); end
        checks++; if (oidx !== 8'd3)  begin errors++; $display("FAIL sid_idx: got %0d, required 3", oidx); end
    endtask

    task automatic test_no_terminator();
        bit to;
        rom = '{24'h300882, 24'h310303, 24'h310404, 24'h310505};
        new_pass();
        exp_q = '{24'h300882, 24'h310303, 24'h310404, 24'h310505};
        pulse_start();
        wait_idle(to);
        repeat (20) @(negedge clk);
        checks++; if (to) begin errors++; $display("FAIL nt_timeout: busy stuck, required idle"); end
        checks++; if (nreq != 4) begin errors++; $display("FAIL nt_nreq: got %0d, required 4", nreq); end
        checks++; if (odone !== 1'b1) begin errors++; $display("FAIL nt_done: got %b, required 1", odone); end
        checks++; if (oerr !== 1'b0)  begin errors++; $display("FAIL nt_err: got %b, required 0", oerr); end
        checks++; if (oidx !== 8'd3)  begin errors++; $display("FAIL nt_idx: got %0d, required 3", oidx); end
        checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL nt_busy: got %b, required 0", obusy); end
    endtask

    initial begin
        rom = '{24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00};
        test_reset();
        test_basic();
        test_nack();
        test_reset_in_wait_ack();
        test_start_in_delay();
        test_no_terminator();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmos_cfg_seq.md
CMOS_CFG_SEQ -- requirements
Module: cmos_cfg_seq

Interface
REQ-001 Parameter TABLE_LEN, default 256, number of entries in the register table.
REQ-002 Parameter TICKS_PER_MS, default 50000, iCLK cycles per 1 ms delay unit.
REQ-003 Parameter PWRUP_MS, default 20, wait in ms between iSTART and the first table access.
REQ-004 iCLK  in  1  single clock for the whole block.
REQ-005 iRST  in  1  reset; synchronous and active-high.
REQ-006 iSTART  in  1  one-cycle pulse that starts a configuration pass; ignored while oBUSY=1.
REQ-007 oROM_ADDR  out  8  table index presented to the table ROM.
REQ-008 iROM_DATA  in  24  table entry {reg_addr[15:0], value[7:0]}, valid 1 cycle after oROM_ADDR.
REQ-009 oSCCB_REQ  out  1  write request to the SCCB master.
REQ-010 oSCCB_ADDR  out  16  register address, stable while oSCCB_REQ=1.
REQ-011 oSCCB_DATA  out  8  register value, stable while oSCCB_REQ=1.
REQ-012 iSCCB_DONE  in  1  one-cycle pulse: transfer finished.
REQ-013 iSCCB_NACK  in  1  qualifies iSCCB_DONE: slave did not acknowledge.
REQ-014 oBUSY  out  1  pass in progress.
REQ-015 oDONE  out  1  sticky: the last pass completed without error.
REQ-016 oERR  out  1  sticky: the last pass aborted on NACK.
REQ-017 oIDX  out  8  index of the current or failing entry.

Function
REQ-018 States: IDLE, PWRUP, FETCH, DECODE, ISSUE, WAIT_ACK, DELAY, FINISH, ERROR.
REQ-019 IDLE: on iSTART, go to PWRUP, clear oDONE/oERR, set oBUSY=1, oIDX=0, load the delay counter with PWRUP_MS*TICKS_PER_MS-1.
REQ-020 PWRUP/DELAY: decrement the counter each cycle; at 0 go to FETCH with oIDX incremented (DELAY) or unchanged (PWRUP).
REQ-021 FETCH: drive oROM_ADDR=oIDX for one cycle, then go to DECODE; ROM latency is 1 cycle.
REQ-022 DECODE, reg_addr==16'hFFFF: end of table, go to FINISH.
REQ-023 DECODE, reg_addr==16'hFFFE: delay entry; load the counter with value*TICKS_PER_MS-1 and go to DELAY.
REQ-024 DECODE, value==0 on a delay entry: no wait; advance oIDX and go to FETCH.
REQ-025 DECODE, any other reg_addr: latch address and value, go to ISSUE.
REQ-026 ISSUE: assert oSCCB_REQ and go to WAIT_ACK.
REQ-027 WAIT_ACK: hold oSCCB_REQ/ADDR/DATA until iSCCB_DONE, then drop oSCCB_REQ in the following cycle.
REQ-028 WAIT_ACK, DONE with NACK=0: advance oIDX and go to FETCH.
REQ-029 WAIT_ACK, DONE with NACK=1: handled per the Configuration section.
REQ-030 oIDX reaching TABLE_LEN-1 without a terminator: that entry is processed, then the block goes to FINISH; no wrap-around.
REQ-031 FINISH: oBUSY=0, oDONE=1, return to IDLE.
REQ-032 ERROR: oBUSY=0, oERR=1, oIDX frozen at the failing entry, return to IDLE.
REQ-033 iSTART while oBUSY=1 is ignored; iSTART in the same cycle as FINISH/ERROR is ignored.
REQ-034 iSCCB_DONE outside WAIT_ACK is ignored.
REQ-035 Delay counter is 32 bits; the product value*TICKS_PER_MS is computed in 32 bits.

Reset
REQ-036 iRST has priority over all inputs; the block returns to IDLE in the next cycle.
REQ-037 Reset values: oSCCB_REQ=0, oBUSY=0, oDONE=0, oERR=0, oIDX=0, oROM_ADDR=0, oSCCB_ADDR=0, oSCCB_DATA=0, counters=0.
REQ-038 Reset mid-transfer drops oSCCB_REQ immediately; any later iSCCB_DONE is ignored.

Configuration
REQ-039 CMOS_CFG_RETRY_EN defined: a NACK reissues the same entry (ISSUE) up to 3 retries; the 4th NACK goes to ERROR.
REQ-040 CMOS_CFG_RETRY_EN defined: the retry counter clears on every entry advance.
REQ-041 CMOS_CFG_RETRY_EN undefined: the first NACK goes to ERROR; no retry counter is present.

Structure
REQ-042 Shared package cmos_cfg_pkg holds the state encoding, CFG_END=16'hFFFF, CFG_DLY=16'hFFFE, and the entry field widths.
REQ-043 The table lives in sub-module cmos_cfg_rom: synchronous 256x24 ROM, 1-cycle latency, contents loaded from an init file.

Verification
REQ-044 Table {3008:82, FFFE:05, 3103:03, FFFF}, TICKS_PER_MS=10, PWRUP_MS=1, all ACK -> writes 3008/82 then 3103/03; gap between them >=50 cycles; oDONE=1, oIDX=3.
REQ-045 NACK on entry 1, retry disabled -> oERR=1, oIDX=1, oDONE=0, no further oSCCB_REQ.
REQ-046 NACK on entry 1 three times then ACK, retry enabled -> 4 requests to the same address, then normal completion with oDONE=1.
REQ-047 iRST asserted in WAIT_ACK -> next cycle oSCCB_REQ=0, oBUSY=0; a later iSCCB_DONE is ignored; a fresh iSTART reruns from entry 0.
REQ-048 iSTART pulsed during DELAY, and a table with no terminator and TABLE_LEN=4 -> the pulse is ignored; exactly 4 writes, then oDONE=1.
